friscv_lsu: RTL and testbench

Parametrised Wishbone load/store unit for the friscv core family, replacing the inline LOAD/STORE states of the single-issue core. It accepts one memory request at a time from the execute stage, drives one or two Wishbone classic bus cycles, aligns and extends load data, and reports completion or error. The bus data width is generic (32 or 64 bits), and accesses that cross a bus-word boundary are split into two beats under a single `cyc_o`.

---
 rtl/friscv_lsu_if.sv | 26 ++
 rtl/friscv_lsu.sv | 213 +++++++++++++++++++++
 tb/tb_friscv_lsu.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_lsu_if.sv
// Wishbone classic bus bundle between the friscv load/store unit and memory.
// The signal suffixes are from the LSU's side; the master modport belongs to the LSU.
interface friscv_lsu_if #(
  parameter int unsigned DBW = 32,
  parameter int unsigned AW  = 32
);
  logic               cyc_o;
  logic               stb_o;
  logic               we_o;
  logic [DBW/8-1:0]   sel_o;
  logic [AW-1:0]      adr_o;
  logic [DBW-1:0]     dat_o;
  logic [DBW-1:0]     dat_i;
  logic               ack_i;
  logic               err_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/friscv_lsu.sv
// Wishbone load/store unit. It runs one request at a time and aligns and extends load data.
// Defining LSU_MISALIGN_EN allows misaligned accesses; an access that crosses a bus word is split into two beats under a single cyc.
module friscv_lsu #(
  parameter int unsigned DBW = 32,
  parameter int unsigned AW  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  input  logic [AW-1:0]    adr_i,
  input  logic [DBW-1:0]   st_dat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [DBW-1:0]   ld_dat_o,
  friscv_lsu_if.master     wb
);

  localparam int unsigned NB = DBW / 8;
  localparam int unsigned OW = $clog2(NB);
`ifdef LSU_MISALIGN_EN
  localparam int unsigned MW = 2 * NB;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_B1,
`ifdef LSU_MISALIGN_EN
    S_GAP,
    S_B2,
`endif
    S_DONE
  } state_t;

  state_t           state;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [OW-1:0]    off_q;
`ifdef LSU_MISALIGN_EN
  logic             split_q;
  logic [NB-1:0]    sel_hi_q;
  logic [DBW-1:0]   wdat_hi_q;
  logic [DBW-1:0]   rdat_lo_q;
  logic [NB-1:0]    req_sel_hi;
  logic [DBW-1:0]   req_whi;
`endif

  logic [OW-1:0]    req_off;
  logic [3:0]       req_bytes;
  logic [NB-1:0]    req_sel;
  logic [DBW-1:0]   req_wlo;
  logic [AW-1:0]    req_base;
  logic             req_illegal;

  always_comb begin
    req_off     = adr_i[OW-1:0];
    req_bytes   = 4'd1 << size_i;
    req_base    = {adr_i[AW-1:OW], {OW{1'b0}}};
    req_illegal = (DBW == 32) && (size_i == 2'd3);
`ifdef LSU_MISALIGN_EN
    {req_sel_hi, req_sel} = ((MW'(1) << req_bytes) - MW'(1)) << req_off;
    {req_whi, req_wlo}    = {{DBW{1'b0}}, st_dat_i} << {req_off, 3'b000};
`else
    req_sel     = ((NB'(1) << req_bytes) - NB'(1)) << req_off;
    req_wlo     = st_dat_i << {req_off, 3'b000};
    req_illegal = req_illegal || ((4'(req_off) & (req_bytes - 4'd1)) != 4'd0);
`endif
  end

  // The raw input is {beat2, beat1}. It is shifted down to the addressed byte, then masked to the
  // access size, then sign- or zero-filled above that size.
  function automatic logic [DBW-1:0] align_load(
    input logic [2*DBW-1:0] raw,
    input logic [OW-1:0]    off,
    input logic [1:0]       size,
    input logic             uns
  );
    logic [DBW-1:0] sh;
    logic [DBW-1:0] keep;
    logic [6:0]     nbits;
    logic           sgn;
    sh    = DBW'(raw >> {off, 3'b000});
    nbits = 7'd8 << size;
    keep  = ~({DBW{1'b1}} << nbits);
    case (size)
      2'd0:    sgn = sh[7];
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[31];
      default: sgn = sh[DBW-1];
    endcase
    return (sh & keep) | ({DBW{~uns & sgn}} & ~keep);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      ld_dat_o  <= '0;
      wb.cyc_o  <= 1'b0;
      wb.stb_o  <= 1'b0;
      wb.we_o   <= 1'b0;
      wb.sel_o  <= '0;
      wb.adr_o  <= '0;
      wb.dat_o  <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
`ifdef LSU_MISALIGN_EN
      split_q   <= 1'b0;
      sel_hi_q  <= '0;
      wdat_hi_q <= '0;
      rdat_lo_q <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        // DONE accepts a new request the same way IDLE does, so requests can run back to back.
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (req_i) begin
            if (req_illegal) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state     <= S_B1;
              busy_o    <= 1'b1;
              wb.cyc_o  <= 1'b1;
              wb.stb_o  <= 1'b1;
              wb.we_o   <= we_i;
              wb.sel_o  <= req_sel;
              wb.adr_o  <= req_base;
              wb.dat_o  <= req_wlo;
              we_q      <= we_i;
              size_q    <= size_i;
              uns_q     <= uns_i;
              off_q     <= req_off;
`ifdef LSU_MISALIGN_EN
              split_q   <= |req_sel_hi;
              sel_hi_q  <= req_sel_hi;
              wdat_hi_q <= req_whi;
`endif
            end
          end
        end

        S_B1: begin
          if (wb.stb_o && (wb.ack_i || wb.err_i)) begin
`ifdef LSU_MISALIGN_EN
            if (!wb.err_i && split_q) begin
              state     <= S_GAP;
              wb.stb_o  <= 1'b0;
              wb.sel_o  <= sel_hi_q;
              wb.adr_o  <= wb.adr_o + AW'(NB);
              wb.dat_o  <= wdat_hi_q;
              rdat_lo_q <= wb.dat_i;
            end else
`endif
            begin
              state    <= S_DONE;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              err_o    <= wb.err_i;
              wb.cyc_o <= 1'b0;
              wb.stb_o <= 1'b0;
              wb.we_o  <= 1'b0;
              wb.sel_o <= '0;
              wb.adr_o <= '0;
              wb.dat_o <= '0;
              if (!wb.err_i && !we_q)
                ld_dat_o <= align_load({{DBW{1'b0}}, wb.dat_i}, off_q, size_q, uns_q);
            end
          end
        end

`ifdef LSU_MISALIGN_EN
        S_GAP: begin
          state    <= S_B2;
          wb.stb_o <= 1'b1;
        end

        S_B2: begin
          if (wb.stb_o && (wb.ack_i || wb.err_i)) begin
            state    <= S_DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            err_o    <= wb.err_i;
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            wb.sel_o <= '0;
            wb.adr_o <= '0;
            wb.dat_o <= '0;
            if (!wb.err_i && !we_q)
              ld_dat_o <= align_load({wb.dat_i, rdat_lo_q}, off_q, size_q, uns_q);
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_lsu.sv
// Self-checking bench for friscv_lsu (DBW=32). It uses a byte-addressed reference memory and a
// Wishbone slave model with random wait states, error injection and spurious acks during the gap.
module tb_friscv_lsu;
  localparam int unsigned DBW = 32;
  localparam int unsigned AW  = 32;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, uns_i;
  logic [1:0]  size_i;
  logic [31:0] adr_i, st_dat_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] ld_dat_o;

  always #5 clk = ~clk;

  friscv_lsu_if #(.DBW(DBW), .AW(AW)) wb ();

  friscv_lsu #(.DBW(DBW), .AW(AW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .size_i   (size_i),
    .uns_i    (uns_i),
    .adr_i    (adr_i),
    .st_dat_i (st_dat_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .ld_dat_o (ld_dat_o),
    .wb       (wb)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] smem [256];
  logic [7:0]  rmem [1024];
  int          wait_cfg = 0;
  int          err_beat = 0;
  bit          spur = 1'b0;
  int          nbeats;
  logic [31:0] b_adr [2];
  logic [3:0]  b_sel [2];
  logic [31:0] b_dat [2];
  bit          gap_seen, cyc_seen;
  logic [31:0] exp_ld;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] val);
    smem[w] = val;
    for (int k = 0; k < 4; k++) rmem[4*w+k] = val[8*k +: 8];
  endtask

  // Wishbone slave. It responds on the negedge so the DUT samples the response on the next rising edge.
  initial begin
    int wc;
    int beat;
    wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.dat_i = '0;
    wc = 0; beat = 0;
    forever begin
      @(negedge clk);
      wb.ack_i = 1'b0;
      wb.err_i = 1'b0;
      if (wb.cyc_o) cyc_seen = 1'b1;
      else beat = 0;
      if (wb.cyc_o && !wb.stb_o && beat == 1) begin
        gap_seen = 1'b1;
        if (spur) begin wb.ack_i = 1'b1; wb.dat_i = $urandom; end
      end
      if (!(wb.cyc_o && wb.stb_o)) begin
        wc = 0;
      end else if (wc < wait_cfg) begin
        wc++;
        wb.dat_i = $urandom;
      end else begin
        wc = 0;
        if (beat < 2) begin
          b_adr[beat] = wb.adr_o; b_sel[beat] = wb.sel_o; b_dat[beat] = wb.dat_o;
        end
        beat++;
        nbeats = beat;
        if (err_beat == beat) begin
          wb.err_i = 1'b1;
          wb.dat_i = $urandom;
        end else begin
          wb.ack_i = 1'b1;
          if (wb.we_o) begin
            for (int l = 0; l < 4; l++)
              if (wb.sel_o[l]) smem[wb.adr_o[9:2]][8*l +: 8] = wb.dat_o[8*l +: 8];
          end else begin
            wb.dat_i = smem[wb.adr_o[9:2]];
          end
        end
      end
    end
  end

  // This task must be called on a negedge. It returns on the negedge where done_o is high.
  task automatic do_req(input string tag, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] adr, input logic [31:0] sd, input int eb,
                        input int waits, input bit sp);
    int bytes, off, lat, exp_nb, exp_lat;
    bit illegal, split, exp_err;
    logic [31:0] base, v;
    logic [3:0]  s1, s2;
    bytes = 1 << size;
    off   = int'(adr % 4);
    base  = adr & ~32'd3;
    illegal = (size == 2'd3);
`ifndef LSU_MISALIGN_EN
    if ((adr % bytes) != 0) illegal = 1'b1;
`endif
    split   = !illegal && (off + bytes > 4);
    exp_err = illegal || eb == 1 || (eb == 2 && split);
    exp_nb  = illegal ? 0 : (eb == 1 ? 1 : (split ? 2 : 1));
    exp_lat = illegal ? 1 : exp_nb * (waits + 1) + (exp_nb == 2 ? 1 : 0) + 1;
    s1 = '0; s2 = '0;
    if (!illegal)
      for (int k = 0; k < bytes; k++)
        if (off + k < 4) s1[off+k] = 1'b1; else s2[off+k-4] = 1'b1;

    wait_cfg = waits; err_beat = eb; spur = sp;
    nbeats = 0; gap_seen = 1'b0; cyc_seen = 1'b0;
    req_i = 1'b1; we_i = we; size_i = size; uns_i = uns; adr_i = adr; st_dat_i = sd;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = $urandom; size_i = 2'($urandom); uns_i = $urandom;
    adr_i = $urandom; st_dat_i = $urandom;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1 && !illegal) begin
        check({tag, ".busy1"}, busy_o, 1);
        check({tag, ".stb1"}, wb.stb_o, 1);
      end
      if (done_o) begin lat = n; break; end
    end
    if (lat == 0) begin
      check({tag, ".timeout"}, 0, 1);
      return;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".err"}, err_o, exp_err);
    check({tag, ".busy"}, busy_o, 0);
    check({tag, ".cyc"}, cyc_seen, !illegal);
    check({tag, ".nbeats"}, nbeats, exp_nb);
    if (exp_nb >= 1) begin
      check({tag, ".adr1"}, b_adr[0], base);
      check({tag, ".sel1"}, b_sel[0], s1);
    end
    if (exp_nb == 2) begin
      check({tag, ".adr2"}, b_adr[1], base + 32'd4);
      check({tag, ".sel2"}, b_sel[1], s2);
      check({tag, ".gap"}, gap_seen, 1);
    end
    if (!exp_err) begin
      if (we) begin
        for (int k = 0; k < bytes; k++) rmem[adr+k] = sd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < bytes; k++) v[8*k +: 8] = rmem[adr+k];
        case (size)
          2'd0:    exp_ld = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
          2'd1:    exp_ld = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          default: exp_ld = v;
        endcase
      end
    end
    check({tag, ".ld"}, ld_dat_o, exp_ld);
  endtask

  initial begin
    #1_000_000;
    check("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prev, sd, a;
    logic [1:0]  sz;
    bit          we, done_seen;
    int          eb;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; uns_i = 1'b0; size_i = '0;
    adr_i = '0; st_dat_i = '0; exp_ld = '0;
    for (int w = 0; w < 256; w++) poke(w, $urandom);
    repeat (2) @(negedge clk);
    check("rst.cyc", wb.cyc_o, 0);
    check("rst.stb", wb.stb_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.done", done_o, 0);
    check("rst.sel", wb.sel_o, 0);
    check("rst.ld", ld_dat_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    poke(32'h40, 32'hDEADBEEF);
    do_req("lw100", 0, 2'd2, 0, 32'h100, 0, 0, 2, 0);
    check("lw100.val", ld_dat_o, 32'hDEADBEEF);

    poke(32'h40, 32'h80011234);
    do_req("lh102s", 0, 2'd1, 0, 32'h102, 0, 0, 0, 0);
    check("lh102s.val", ld_dat_o, 32'hFFFF8001);
    do_req("lh102u", 0, 2'd1, 1, 32'h102, 0, 0, 1, 0);
    check("lh102u.val", ld_dat_o, 32'h00008001);

    do_req("sw103", 1, 2'd2, 0, 32'h103, 32'h11223344, 0, 0, 1);
`ifdef LSU_MISALIGN_EN
    check("sw103.d1", b_dat[0][31:24], 8'h44);
    check("sw103.d2", b_dat[1][23:0], 24'h112233);
`endif

    do_req("ld64", 0, 2'd3, 0, 32'h100, 0, 0, 0, 0);

    poke(32'h40, 32'hCAFEF00D);
    do_req("lw100b", 0, 2'd2, 0, 32'h100, 0, 0, 0, 0);
    prev = ld_dat_o;
    do_req("lw102e", 0, 2'd2, 0, 32'h102, 0, 1, 0, 0);
    check("lw102e.hold", ld_dat_o, prev);

    // Reset is asserted while beat 1 is waiting for its ack.
    wait_cfg = 6; err_beat = 0; spur = 1'b0;
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; uns_i = 1'b0; adr_i = 32'h100;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    check("rstmid.stb_before", wb.stb_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid.cyc", wb.cyc_o, 0);
    check("rstmid.stb", wb.stb_o, 0);
    check("rstmid.we", wb.we_o, 0);
    check("rstmid.busy", busy_o, 0);
    check("rstmid.done", done_o, 0);
    check("rstmid.err", err_o, 0);
    check("rstmid.sel", wb.sel_o, 0);
    check("rstmid.adr", wb.adr_o, 0);
    check("rstmid.dat", wb.dat_o, 0);
    check("rstmid.ld", ld_dat_o, 0);
    exp_ld = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) done_seen = 1'b1;
    end
    check("rstmid.nodone", done_seen, 0);
    do_req("lw200", 0, 2'd2, 0, 32'h200, 0, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      we = $urandom_range(0, 1);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 1016);
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
      sd = $urandom;
      eb = (!we && $urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      do_req($sformatf("rnd%0d", t), we, sz, 1'($urandom_range(0, 1)), a, sd, eb,
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int w = 0; w < 256; w++)
      check($sformatf("mem%0d", w), smem[w],
            {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
